// File: rtl/seg7_pkg.sv
// Shared types and widths for the 7-segment scan multiplexer.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam int NIB_W = 4;
    localparam int SEG_W = 7;

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timer: counts 0..limit-1, flags the last count and wraps to zero.
module seg7_scan_timer #(
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic [CW-1:0] limit_i,
    output logic          expired_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = (cnt_q == limit_i - CW'(1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || expired_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit common-anode 7-segment scanner with frame-synchronous digit updates.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        load,
    input  logic [NIB_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    output logic [NIB_W-1:0]            nib_out,
    input  logic [SEG_W-1:0]            seg_in,
    output logic [SEG_W-1:0]            seg_out,
    output logic                        dp_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic                        frame_done,
    output state_t                      dbg_state_o
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int DW   = NIB_W * NUM_DIGITS;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [DW-1:0]           pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [DW-1:0]           shad_dig_q, shad_dig_d;
    logic [NUM_DIGITS-1:0]   shad_dp_q, shad_dp_d;
    logic [NIB_W-1:0]        nib_q, nib_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic                    timer_clr;
    logic [CW-1:0]           timer_limit;
    logic                    expired;
    logic                    enter_blank;
    logic [NUM_DIGITS-1:0]   lit;
    logic [NUM_DIGITS-1:0]   onehot;

    seg7_scan_timer #(.CW(CW)) u_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (timer_clr),
        .limit_i   (timer_limit),
        .expired_o (expired)
    );

`ifdef SEG7_LZ_BLANK_EN
    // A digit stays dark while it and every more significant nibble are zero.
    always_comb begin
        logic nz;
        nz  = 1'b0;
        lit = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            nz     = nz | (shad_dig_q[k*NIB_W +: NIB_W] != '0);
            lit[k] = nz;
        end
        lit[0] = 1'b1;
    end
`else
    assign lit = '1;
`endif

    assign onehot      = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    assign timer_limit = (state_q == SHOW) ? CW'(DWELL_CYCLES) : CW'(BLANK_CYCLES);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        shad_dig_d   = shad_dig_q;
        shad_dp_d    = shad_dp_q;
        nib_d        = nib_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        an_d         = an_q;
        frame_d      = 1'b0;
        timer_clr    = 1'b0;
        enter_blank  = 1'b0;

        // load is a single-cycle strobe with no back-pressure; the last strobe before a frame boundary wins.
        if (load) begin
            pend_dig_d   = digits_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end

        if (!en) begin
            state_d   = IDLE;
            idx_d     = '0;
            an_d      = '0;
            dp_d      = 1'b0;
            timer_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = BLANK;
                    idx_d       = '0;
                    timer_clr   = 1'b1;
                    enter_blank = 1'b1;
                end
                BLANK: begin
                    if (expired) begin
                        state_d = SHOW;
                        seg_d   = seg_in;
                        an_d    = lit[idx_q] ? onehot : '0;
                        dp_d    = lit[idx_q] & shad_dp_q[idx_q];
                    end
                end
                SHOW: begin
                    if (expired) begin
                        state_d     = BLANK;
                        an_d        = '0;
                        dp_d        = 1'b0;
                        enter_blank = 1'b1;
                        if (idx_q == IW'(NUM_DIGITS - 1)) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Frame boundary: a load arriving on this very cycle is taken directly.
        if (enter_blank) begin
            if (idx_d == '0 && (load || pend_valid_q)) begin
                shad_dig_d   = load ? digits_in : pend_dig_q;
                shad_dp_d    = load ? dp_in : pend_dp_q;
                pend_valid_d = 1'b0;
            end
            nib_d = shad_dig_d[idx_d*NIB_W +: NIB_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            shad_dig_q   <= '0;
            shad_dp_q    <= '0;
            nib_q        <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            an_q         <= '0;
            frame_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            shad_dig_q   <= shad_dig_d;
            shad_dp_q    <= shad_dp_d;
            nib_q        <= nib_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_q      <= frame_d;
        end
    end

    assign nib_out     = nib_q;
    assign seg_out     = seg_q;
    assign dp_out      = dp_q;
    assign an_out      = an_q;
    assign frame_done  = frame_q;
    assign dbg_state_o = state_q;

endmodule
